// File: rtl/sram_port_arbiter_if.sv
// One sram-like port: address phase (req/addr_ok) and in-order response (data_ok/rdata).
// The master drives the request payload; the slave answers with addr_ok, data_ok and rdata.
interface sram_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between the inst and data requesters.
// Data wins by default, a starved inst is forced through, and responses route via an in-order owner FIFO.
module sram_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_port_arbiter_if.slave   inst,
    sram_port_arbiter_if.slave   data,
    sram_port_arbiter_if.master  m,
    output logic                 err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             lock_valid_reg;
    logic             lock_owner_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [3:0]       starve_reg;
    logic             err_reg;
    logic [DEPTH-1:0] fifo_q;

    logic sel;
    logic sel_req;
    logic full;
    logic fire;
    logic resp;
    logic head;

    assign full = (count_reg == CNT_W'(DEPTH));

    // Owner 0 is inst, 1 is data; an un-accepted request keeps its grant.
    always_comb begin
        sel = 1'b0;
        if (lock_valid_reg)
            sel = lock_owner_reg;
        else if (inst.req && data.req && (starve_reg == 4'(STARVE_LIMIT)))
            sel = 1'b0;
        else if (data.req)
            sel = 1'b1;
        else
            sel = 1'b0;
    end

    assign sel_req = sel ? data.req : inst.req;

    assign m.req   = resetn & ~full & sel_req;
    assign m.wr    = sel ? data.wr    : inst.wr;
    assign m.wstrb = sel ? data.wstrb : inst.wstrb;
    assign m.addr  = sel ? data.addr  : inst.addr;
    assign m.wdata = sel ? data.wdata : inst.wdata;

    assign fire         = m.req & m.addr_ok;
    assign inst.addr_ok = fire & ~sel;
    assign data.addr_ok = fire & sel;

    assign resp         = m.data_ok & (count_reg != '0);
    assign head         = fifo_q[rd_ptr_reg];
    assign inst.data_ok = resp & ~head;
    assign data.data_ok = resp & head;
    assign inst.rdata   = inst.data_ok ? m.rdata : 32'h0;
    assign data.rdata   = data.data_ok ? m.rdata : 32'h0;

    assign err = err_reg;

    // One owner bit per FIFO slot, written only when the write pointer points at it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
            logic entry_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    entry_reg <= 1'b0;
                else if (fire && (wr_ptr_reg == PTR_W'(gi)))
                    entry_reg <= sel;
            end
            assign fifo_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid_reg <= 1'b0;
            lock_owner_reg <= 1'b0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (fire) begin
                lock_valid_reg <= 1'b0;
            end else if (m.req) begin
                lock_valid_reg <= 1'b1;
                lock_owner_reg <= sel;
            end

            if (fire)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (resp)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

            case ({fire, resp})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            if (m.data_ok && (count_reg == '0))
                err_reg <= 1'b1;

            // Counts data wins that overtook a waiting inst request.
            if (fire && sel && inst.req) begin
                if (starve_reg != 4'(STARVE_LIMIT))
                    starve_reg <= starve_reg + 4'd1;
            end else if ((fire && !sel) || !inst.req) begin
                starve_reg <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_sram_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic err;

    always #5 clk = ~clk;

    sram_port_arbiter_if inst_if ();
    sram_port_arbiter_if data_if ();
    sram_port_arbiter_if m_if ();

    sram_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .resetn(resetn),
        .inst  (inst_if),
        .data  (data_if),
        .m     (m_if),
        .err   (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: owners of accepted requests in order, a pending grant, starve count, sticky error.
    bit q[$];
    bit held     = 1'b0;
    bit held_own = 1'b0;
    int starve   = 0;
    bit m_err    = 1'b0;
    bit inst_fired = 1'b0;
    bit data_fired = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit sel, full, e_mreq, fire, resp, h;
        if (!resetn) begin
            check("rst_m_req", m_if.req, 0);
            check("rst_inst_addr_ok", inst_if.addr_ok, 0);
            check("rst_data_addr_ok", data_if.addr_ok, 0);
            check("rst_inst_data_ok", inst_if.data_ok, 0);
            check("rst_data_data_ok", data_if.data_ok, 0);
            check("rst_err", err, 0);
            q.delete();
            held = 0; held_own = 0; starve = 0; m_err = 0;
            inst_fired = 0; data_fired = 0;
        end else begin
            if (held)
                sel = held_own;
            else if (inst_if.req && data_if.req && starve == LIM)
                sel = 0;
            else
                sel = data_if.req;
            full   = (q.size() == DEPTH);
            e_mreq = !full && (sel ? data_if.req : inst_if.req);
            fire   = e_mreq && m_if.addr_ok;
            resp   = m_if.data_ok && (q.size() > 0);
            h      = (q.size() > 0) ? q[0] : 1'b0;

            check("m_req", m_if.req, e_mreq);
            check("inst_addr_ok", inst_if.addr_ok, fire && !sel);
            check("data_addr_ok", data_if.addr_ok, fire && sel);
            check("inst_data_ok", inst_if.data_ok, resp && !h);
            check("data_data_ok", data_if.data_ok, resp && h);
            check("err", err, m_err);
            if (e_mreq) begin
                check("m_addr", m_if.addr, sel ? data_if.addr : inst_if.addr);
                check("m_wdata", m_if.wdata, sel ? data_if.wdata : inst_if.wdata);
                check("m_wstrb", m_if.wstrb, sel ? data_if.wstrb : inst_if.wstrb);
                check("m_wr", m_if.wr, sel ? data_if.wr : inst_if.wr);
            end
            if (resp && !h) check("inst_rdata", inst_if.rdata, m_if.rdata);
            if (resp && h)  check("data_rdata", data_if.rdata, m_if.rdata);

            if (fire)
                $display("%0t grant %s addr=%h wr=%0d", $time, sel ? "data" : "inst",
                         sel ? data_if.addr : inst_if.addr, sel ? data_if.wr : inst_if.wr);
            if (resp)
                $display("%0t resp  %s rdata=%h", $time, h ? "data" : "inst", m_if.rdata);

            if (fire) held = 0;
            else if (e_mreq) begin held = 1; held_own = sel; end
            if (m_if.data_ok && q.size() == 0) m_err = 1;
            if (resp) void'(q.pop_front());
            if (fire) q.push_back(sel);
            if (fire && sel && inst_if.req) starve = (starve < LIM) ? starve + 1 : LIM;
            else if ((fire && !sel) || !inst_if.req) starve = 0;
            inst_fired = fire && !sel;
            data_fired = fire && sel;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_if.req = 0; inst_if.wr = 0; inst_if.wstrb = 4'h0;
        inst_if.addr = 32'h1c001000; inst_if.wdata = 32'h0;
        data_if.req = 0; data_if.wr = 0; data_if.wstrb = 4'h0;
        data_if.addr = 32'h1c000100; data_if.wdata = 32'h0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 32'h0;
    endtask

    initial begin
        bit exp_d[6];
        exp_d = '{1, 1, 1, 1, 0, 1};
        idle();
        #1 resetn = 0;
        #11 resetn = 1;

        // Data-only read with single-cycle response
        cyc(); data_if.req = 1; m_if.addr_ok = 1;
        #1 check("t1_data_addr_ok", data_if.addr_ok, 1);
        check("t1_m_addr", m_if.addr, 32'h1c000100);
        cyc(); data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'hdeadbeef;
        #1 check("t1_data_data_ok", data_if.data_ok, 1);
        check("t1_data_rdata", data_if.rdata, 32'hdeadbeef);
        check("t1_inst_data_ok", inst_if.data_ok, 0);
        cyc(); idle();

        // Starvation override: D,D,D,D,I,D
        for (int i = 0; i < 6; i++) begin
            cyc(); inst_if.req = 1; data_if.req = 1; m_if.addr_ok = 1;
            m_if.data_ok = (i > 0); m_if.rdata = 32'h100 + i;
            #1 check($sformatf("t2_grant%0d_data", i), data_if.addr_ok, exp_d[i]);
            check($sformatf("t2_grant%0d_inst", i), inst_if.addr_ok, !exp_d[i]);
        end
        cyc(); idle(); m_if.data_ok = 1;
        cyc(); idle();

        // Lock holds inst grant while address is stalled, then full blocks data
        cyc(); inst_if.req = 1;
        #1 check("t3_m_req", m_if.req, 1);
        check("t3_m_addr0", m_if.addr, 32'h1c001000);
        cyc(); data_if.req = 1;
        #1 check("t3_m_addr1", m_if.addr, 32'h1c001000);
        check("t3_data_addr_ok1", data_if.addr_ok, 0);
        cyc();
        #1 check("t3_m_addr2", m_if.addr, 32'h1c001000);
        cyc(); m_if.addr_ok = 1;
        #1 check("t3_inst_addr_ok", inst_if.addr_ok, 1);
        cyc(); inst_if.req = 0;
        #1 check("t3_data_addr_ok", data_if.addr_ok, 1);
        cyc(); data_if.addr = 32'h1c000200;
        #1 check("t4_full_m_req", m_if.req, 0);
        cyc(); m_if.data_ok = 1; m_if.rdata = 32'h77;
        #1 check("t4_pop_inst_data_ok", inst_if.data_ok, 1);
        check("t4_pop_same_cycle_m_req", m_if.req, 0);
        cyc(); m_if.data_ok = 0;
        #1 check("t4_after_pop_m_req", m_if.req, 1);
        check("t4_after_pop_data_addr_ok", data_if.addr_ok, 1);
        cyc(); data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        cyc();
        cyc(); idle();

        // In-order routing and sticky err
        cyc(); inst_if.req = 1; m_if.addr_ok = 1;
        #1 check("t5_inst_addr_ok", inst_if.addr_ok, 1);
        cyc(); inst_if.req = 0; data_if.req = 1;
        #1 check("t5_data_addr_ok", data_if.addr_ok, 1);
        cyc(); data_if.req = 0; m_if.data_ok = 1; m_if.rdata = 32'h11;
        #1 check("t5_inst_data_ok", inst_if.data_ok, 1);
        check("t5_inst_rdata", inst_if.rdata, 32'h11);
        check("t5_data_data_ok0", data_if.data_ok, 0);
        cyc(); m_if.rdata = 32'h22;
        #1 check("t5_data_data_ok", data_if.data_ok, 1);
        check("t5_data_rdata", data_if.rdata, 32'h22);
        cyc(); m_if.rdata = 32'h33;
        #1 check("t5_empty_inst_data_ok", inst_if.data_ok, 0);
        check("t5_empty_data_data_ok", data_if.data_ok, 0);
        check("t5_err_not_yet", err, 0);
        cyc(); m_if.data_ok = 0;
        #1 check("t5_err_set", err, 1);
        cyc();
        #1 check("t5_err_sticky", err, 1);

        // Async reset with two outstanding
        cyc(); inst_if.req = 1; m_if.addr_ok = 1;
        cyc(); inst_if.req = 0; data_if.req = 1;
        cyc(); m_if.data_ok = 1; m_if.rdata = 32'h44;
        #1 check("t6_pre_inst_data_ok", inst_if.data_ok, 1);
        check("t6_pre_full_m_req", m_if.req, 0);
        #1 resetn = 0;
        #1 check("t6_rst_m_req", m_if.req, 0);
        check("t6_rst_inst_data_ok", inst_if.data_ok, 0);
        check("t6_rst_data_data_ok", data_if.data_ok, 0);
        check("t6_rst_data_addr_ok", data_if.addr_ok, 0);
        check("t6_rst_err", err, 0);
        cyc(); idle();
        #1 resetn = 1;
        cyc(); data_if.req = 1; m_if.addr_ok = 1;
        #1 check("t6_fresh_data_addr_ok", data_if.addr_ok, 1);
        check("t6_fresh_err", err, 0);
        cyc(); data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h55;
        #1 check("t6_fresh_data_data_ok", data_if.data_ok, 1);
        check("t6_fresh_inst_data_ok", inst_if.data_ok, 0);
        cyc(); idle();

        // Randomized protocol-legal traffic
        for (int i = 0; i < 1500; i++) begin
            cyc();
            if (!inst_if.req || inst_fired) begin
                inst_if.req   = ($urandom_range(0, 9) < 6);
                inst_if.wr    = $urandom_range(0, 1);
                inst_if.wstrb = 4'($urandom);
                inst_if.addr  = $urandom;
                inst_if.wdata = $urandom;
            end
            if (!data_if.req || data_fired) begin
                data_if.req   = ($urandom_range(0, 9) < 6);
                data_if.wr    = $urandom_range(0, 1);
                data_if.wstrb = 4'($urandom);
                data_if.addr  = $urandom;
                data_if.wdata = $urandom;
            end
            m_if.addr_ok = ($urandom_range(0, 9) < 7);
            m_if.data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_if.rdata   = $urandom;
        end
        cyc(); idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
